serial_transmitter: RTL and testbench



---
 rtl/serial_transmitter_if.sv | 43 ++++
 rtl/serial_transmitter.sv | 93 +++++++++
 tb/tb_serial_transmitter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// serial_transmitter_if
// Load handshake and serial link signals of the serial transmitter.
// Revision: 1.0
// ============================================================================
interface serial_transmitter_if #(
  parameter int W = 8
);
  logic         en;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         out;
  logic         out_valid;
  logic         busy;
  logic         done;

  // Word source / link consumer side
  modport master (
    output en,
    output load_valid,
    output load_data,
    input  load_ready,
    input  out,
    input  out_valid,
    input  busy,
    input  done
  );

  // Transmitter side
  modport slave (
    input  en,
    input  load_valid,
    input  load_data,
    output load_ready,
    output out,
    output out_valid,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// serial_transmitter
// Parallel-to-serial transmitter, LSB first, one bit per enabled cycle.
// Revision: 1.0
// ============================================================================
module serial_transmitter #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_transmitter_if.slave  bus
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  sreg;
  logic [W-1:0]  sreg_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          done_r;
  logic          done_nxt;
  logic          last_bit;

  // The final bit of a word is consumed on this edge; a new word may load here.
  assign last_bit = (state == SHIFT) && bus.en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          sreg_nxt  = bus.load_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (cnt == LAST) begin
            done_nxt = 1'b1;
            if (bus.load_valid) begin
              sreg_nxt = bus.load_data;
              cnt_nxt  = '0;
            end else begin
              sreg_nxt  = sreg >> 1;
              state_nxt = IDLE;
            end
          end else begin
            sreg_nxt = sreg >> 1;
            cnt_nxt  = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.out        = (state == SHIFT) ? sreg[0] : 1'b0;
  assign bus.out_valid  = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.load_ready = (state == IDLE) || last_bit;
  assign bus.done       = done_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// tb_serial_transmitter
// Randomized scoreboard bench for serial_transmitter (W=8 and W=1 instances).
// ============================================================================
module tb_serial_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_transmitter_if #(.W(8)) bus8 ();
  serial_transmitter_if #(.W(1)) bus1 ();

  serial_transmitter #(.W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  serial_transmitter #(.W(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of bits still to be delivered, each tagged with its word
  typedef struct {
    logic       b;
    logic       last;
    logic [7:0] word;
  } bit_t;

  bit_t       q[$];
  logic       exp_done = 1'b0;
  logic       will_accept = 1'b0;
  logic       mon_en = 1'b0;
  logic [7:0] rx = '0;
  int         en_mode = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ready;
      logic nd;
      bit_t e;
      exp_ready = (q.size() == 0) || (q.size() == 1 && bus8.en);
      chk("busy", 32'(bus8.busy), 32'(q.size() != 0));
      chk("out_valid", 32'(bus8.out_valid), 32'(q.size() != 0));
      chk("out", 32'(bus8.out), 32'((q.size() != 0) ? q[0].b : 1'b0));
      chk("load_ready", 32'(bus8.load_ready), 32'(exp_ready));
      chk("done", 32'(bus8.done), 32'(exp_done));
      nd = 1'b0;
      will_accept = 1'b0;
      if (reset) begin
        q.delete();
      end else begin
        if (q.size() != 0 && bus8.en) begin
          e  = q.pop_front();
          rx = {bus8.out, rx[7:1]};
          if (e.last) begin
            nd = 1'b1;
            chk("rx_word", 32'(rx), 32'(e.word));
          end
        end
        if (bus8.load_valid && exp_ready) begin
          will_accept = 1'b1;
          for (int i = 0; i < 8; i++)
            q.push_back('{b: bus8.load_data[i], last: (i == 7), word: bus8.load_data});
        end
      end
      exp_done = nd;
    end
  end

  // Enable pattern generator
  initial begin
    bus8.en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       bus8.en = 1'b1;
        1:       bus8.en = ~bus8.en;
        default: bus8.en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    bus8.load_valid = 1'b1;
    bus8.load_data  = d;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!will_accept && n < 300);
    if (!will_accept) begin
      miscompares++;
      $display("FAIL accept_timeout: word %0h not accepted after %0d cycles", d, n);
    end
    #1;
    bus8.load_valid = 1'b0;
    bus8.load_data  = $urandom();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q.size() != 0 && n < 500);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_timeout: %0d bits still pending", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus8.load_valid = 1'b0;
    bus8.load_data  = '0;
    bus1.en         = 1'b0;
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, continuous enable
    en_mode = 0;
    send(8'hA5);
    wait_idle();

    // Gapped enable
    en_mode = 1;
    send(8'h3C);
    wait_idle();

    // Back-to-back words
    en_mode = 0;
    send(8'h01);
    send(8'h80);
    wait_idle();

    // Backpressure: next word offered mid-word
    send(8'h00);
    repeat (2) @(posedge clk);
    #1;
    send(8'hFF);
    wait_idle();

    // Reset mid-word
    send(8'hF0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h5A);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      en_mode = $urandom_range(0, 2);
      send(8'($urandom()));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    // W=1 instance: 1 then 0 back-to-back
    bus1.en         = 1'b1;
    bus1.load_valid = 1'b1;
    bus1.load_data  = 1'b1;
    @(negedge clk);
    chk("w1_idle_ready", 32'(bus1.load_ready), 32'd1);
    chk("w1_idle_valid", 32'(bus1.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus1.load_data = 1'b0;
    @(negedge clk);
    chk("w1_bit0_out", 32'(bus1.out), 32'd1);
    chk("w1_bit0_valid", 32'(bus1.out_valid), 32'd1);
    chk("w1_bit0_ready", 32'(bus1.load_ready), 32'd1);
    chk("w1_bit0_done", 32'(bus1.done), 32'd0);
    @(posedge clk);
    #1;
    bus1.load_valid = 1'b0;
    @(negedge clk);
    chk("w1_bit1_out", 32'(bus1.out), 32'd0);
    chk("w1_bit1_valid", 32'(bus1.out_valid), 32'd1);
    chk("w1_done1", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("w1_end_busy", 32'(bus1.busy), 32'd0);
    chk("w1_done2", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("w1_done_low", 32'(bus1.done), 32'd0);
    chk("w1_end_ready", 32'(bus1.load_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
